axis_pattern_gen: RTL and testbench

AXI-Stream frame transmitter producing framed counter-pattern traffic with programmable frame length, inter-frame gap and frame count. It is the master endpoint that drives our stream chain (skid buffers, FIFOs, width converters) during bring-up and in loopback benches. All master outputs are registered and obey full AXI-Stream backpressure rules.

---
 rtl/axis_pattern_gen.sv | 170 +++++++++++++++++
 tb/tb_axis_pattern_gen.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pattern_gen.sv
// AXI-Stream master emitting framed counter patterns with programmable length, gap and frame count.
// Optional macro AXIS_PATTERN_GEN_SEQNUM_EN: beat 0 of each frame carries the frame sequence number.
module axis_pattern_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_WIDTH  = 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  cfg_enable,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [GAP_WIDTH-1:0]  cfg_gap,
    input  logic [15:0]           cfg_count,
    output logic                  busy,
    output logic                  frame_done,
    output logic [31:0]           frames_sent,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [1:0]            dbg_state
);

    // Handshake: a beat transfers on a rising edge where tvalid and tready are both high;
    // while tvalid is high and tready low, tvalid/tdata/tlast hold their values.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [GAP_WIDTH-1:0]  gap_q, gap_d;
    logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0]           count_q, count_d;
    logic [31:0]           frames_q, frames_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  frame_done_q, frame_done_d;

    logic                  start_frame;
    logic [LEN_WIDTH-1:0]  beat_next;
    logic [31:0]           frames_inc;

    assign beat_next  = beat_q + LEN_WIDTH'(1);
    assign frames_inc = frames_q + 32'd1;

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        len_d        = len_q;
        gap_d        = gap_q;
        gap_cnt_d    = gap_cnt_q;
        count_d      = count_q;
        frames_d     = frames_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        frame_done_d = 1'b0;
        start_frame  = 1'b0;

        case (state_q)
            S_IDLE: begin
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                if (cfg_enable) begin
                    count_d     = cfg_count;
                    frames_d    = '0;
                    start_frame = 1'b1;
                end
            end
            S_SEND: begin
                if (m_axis_tready) begin
                    if (tlast_q) begin
                        frames_d     = frames_inc;
                        frame_done_d = 1'b1;
                        tvalid_d     = 1'b0;
                        tlast_d      = 1'b0;
                        if (count_q != 16'd0 && frames_inc == {16'd0, count_q}) begin
                            state_d = S_DONE;
                        end else if (!cfg_enable) begin
                            state_d = S_IDLE;
                        end else if (gap_q == '0) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d   = S_GAP;
                            gap_cnt_d = gap_q - GAP_WIDTH'(1);
                        end
                    end else begin
                        beat_d  = beat_next;
                        tdata_d = DATA_WIDTH'(beat_next);
                        tlast_d = (beat_next == len_q);
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    start_frame = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
                end
            end
            S_DONE: begin
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                if (!cfg_enable) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // First beat of every frame re-latches the frame configuration.
        if (start_frame) begin
            state_d  = S_SEND;
            len_d    = cfg_len;
            gap_d    = cfg_gap;
            beat_d   = '0;
            tvalid_d = 1'b1;
            tlast_d  = (cfg_len == '0);
`ifdef AXIS_PATTERN_GEN_SEQNUM_EN
            tdata_d  = DATA_WIDTH'(frames_d);
`else
            tdata_d  = '0;
`endif
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            len_q        <= '0;
            gap_q        <= '0;
            gap_cnt_q    <= '0;
            count_q      <= '0;
            frames_q     <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            len_q        <= len_d;
            gap_q        <= gap_d;
            gap_cnt_q    <= gap_cnt_d;
            count_q      <= count_d;
            frames_q     <= frames_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign busy          = (state_q == S_SEND) || (state_q == S_GAP);
    assign frame_done    = frame_done_q;
    assign frames_sent   = frames_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Self-checking bench for axis_pattern_gen: randomized backpressure and configs against a frame-level model.
module tb_axis_pattern_gen;
    localparam int DATA_WIDTH = 16;
    localparam int LEN_WIDTH  = 16;
    localparam int GAP_WIDTH  = 8;
`ifdef AXIS_PATTERN_GEN_SEQNUM_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  areset = 1'b1;
    logic                  cfg_enable = 1'b0;
    logic [LEN_WIDTH-1:0]  cfg_len = '0;
    logic [GAP_WIDTH-1:0]  cfg_gap = '0;
    logic [15:0]           cfg_count = '0;
    logic                  busy;
    logic                  frame_done;
    logic [31:0]           frames_sent;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tlast;
    logic                  m_axis_tready = 1'b0;
    logic [1:0]            dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_WIDTH:0] exp_q[$];
    logic [DATA_WIDTH:0] got_q[$];
    int gaps_q[$];
    int fd_pulses, fd_bad, stab_err, first_valid, last_hs_cyc, tlast_hs_cyc;

    axis_pattern_gen #(
        .DATA_WIDTH(DATA_WIDTH),
        .LEN_WIDTH (LEN_WIDTH),
        .GAP_WIDTH (GAP_WIDTH)
    ) dut (
        .aclk         (clk),
        .areset       (areset),
        .cfg_enable   (cfg_enable),
        .cfg_len      (cfg_len),
        .cfg_gap      (cfg_gap),
        .cfg_count    (cfg_count),
        .busy         (busy),
        .frame_done   (frame_done),
        .frames_sent  (frames_sent),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Reference model: beat k of frame f carries k, except beat 0 carries f when sequence numbering is on.
    function automatic logic [DATA_WIDTH:0] exp_beat(input int f, input int k, input int len);
        logic [DATA_WIDTH-1:0] d;
        d = DATA_WIDTH'(k);
        if (SEQ && k == 0) d = DATA_WIDTH'(f);
        return {(k == len), d};
    endfunction

    task automatic build_exp(input int len, input int frames);
        exp_q.delete();
        for (int f = 0; f < frames; f++)
            for (int k = 0; k <= len; k++)
                exp_q.push_back(exp_beat(f, k, len));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs the sink for ncycles, recording accepted beats and observed timing; drops enable after drop_at beats.
    task automatic collect(input int ncycles, input int ready_pct, input int drop_at);
        bit prev_stall;
        logic [DATA_WIDTH-1:0] prev_data;
        logic prev_last;
        int hs_cnt, open_tlast;
        got_q.delete();
        gaps_q.delete();
        fd_pulses = 0; fd_bad = 0; stab_err = 0; first_valid = -1;
        last_hs_cyc = -1; tlast_hs_cyc = -10; open_tlast = -1;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; hs_cnt = 0;
        for (int c = 0; c < ncycles; c++) begin
            m_axis_tready = ($urandom_range(99) < ready_pct);
            if (prev_stall && (!m_axis_tvalid || m_axis_tdata != prev_data || m_axis_tlast != prev_last))
                stab_err++;
            if (frame_done) fd_pulses++;
            if ((tlast_hs_cyc == c - 1) != frame_done) fd_bad++;
            if (m_axis_tvalid && first_valid < 0) first_valid = c;
            if (m_axis_tvalid && open_tlast >= 0) begin
                gaps_q.push_back(c - open_tlast - 1);
                open_tlast = -1;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                got_q.push_back({m_axis_tlast, m_axis_tdata});
                last_hs_cyc = c;
                hs_cnt++;
                if (m_axis_tlast) begin
                    open_tlast = c;
                    tlast_hs_cyc = c;
                end
                if (hs_cnt == drop_at) cfg_enable = 1'b0;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            tick();
        end
    endtask

    task automatic go_idle();
        cfg_enable = 1'b0;
        for (int i = 0; i < 60 && (busy || m_axis_tvalid); i++) begin
            m_axis_tready = 1'b1;
            tick();
        end
        n_checks++;
        if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            $display("FAIL go_idle: busy=%0b tvalid=%0b, required 0/0 after disable", busy, m_axis_tvalid);
            n_errors++;
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        areset = 1'b1;
        cfg_enable = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0) begin
            $display("FAIL reset_axis: tvalid=%0b tlast=%0b tdata=%0h, required 0/0/0", m_axis_tvalid, m_axis_tlast, m_axis_tdata);
            n_errors++;
        end
        n_checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0 || frames_sent !== 32'd0) begin
            $display("FAIL reset_status: busy=%0b frame_done=%0b frames_sent=%0d, required 0/0/0", busy, frame_done, frames_sent);
            n_errors++;
        end
        areset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        cfg_len = 16'd3; cfg_gap = 8'd0; cfg_count = 16'd2; cfg_enable = 1'b1;
        build_exp(3, 2);
        collect(12, 100, -1);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            $display("FAIL basic_len: got %0d beats, required %0d", got_q.size(), exp_q.size());
            n_errors++;
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL basic_beat[%0d]: got last/data %h, required %h", i, got_q[i], exp_q[i]);
                n_errors++;
            end
        end
        n_checks++;
        if (first_valid != 1 || last_hs_cyc != 8) begin
            $display("FAIL basic_timing: first valid cycle %0d last beat cycle %0d, required 1 and 8", first_valid, last_hs_cyc);
            n_errors++;
        end
        n_checks++;
        if (frames_sent !== 32'd2 || m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL basic_done: frames_sent=%0d tvalid=%0b busy=%0b, required 2/0/0", frames_sent, m_axis_tvalid, busy);
            n_errors++;
        end
        n_checks++;
        if (fd_pulses != 2 || fd_bad != 0) begin
            $display("FAIL basic_frame_done: pulses=%0d misplaced=%0d, required 2 and 0", fd_pulses, fd_bad);
            n_errors++;
        end
        // Still enabled: a finished run must not restart until enable goes low.
        repeat (3) tick();
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || frames_sent !== 32'd2) begin
            $display("FAIL basic_hold: tvalid=%0b frames_sent=%0d, required 0 and 2", m_axis_tvalid, frames_sent);
            n_errors++;
        end
        go_idle();
    endtask

    task automatic test_single_beat();
        int frames, exp_fd;
        cfg_len = 16'd0; cfg_gap = 8'd3; cfg_count = 16'd0; cfg_enable = 1'b1;
        collect(40, 100, -1);
        frames = got_q.size();
        build_exp(0, frames);
        n_checks++;
        if (frames != 10) begin
            $display("FAIL single_count: got %0d single-beat frames, required 10", frames);
            n_errors++;
        end
        for (int i = 0; i < frames; i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL single_beat[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
                n_errors++;
            end
        end
        for (int i = 0; i < gaps_q.size(); i++) begin
            n_checks++;
            if (gaps_q[i] != 3) begin
                $display("FAIL single_gap[%0d]: got %0d idle cycles, required 3", i, gaps_q[i]);
                n_errors++;
            end
        end
        exp_fd = (tlast_hs_cyc == 39) ? frames - 1 : frames;
        n_checks++;
        if (fd_pulses != exp_fd || fd_bad != 0) begin
            $display("FAIL single_frame_done: pulses=%0d misplaced=%0d, required %0d and 0", fd_pulses, fd_bad, exp_fd);
            n_errors++;
        end
        go_idle();
    endtask

    task automatic test_backpressure();
        int len, gap, cnt, pct;
        for (int it = 0; it < 5; it++) begin
            len = (it == 0) ? 7 : $urandom_range(9);
            gap = (it == 0) ? 0 : $urandom_range(3);
            cnt = $urandom_range(1, 3);
            pct = (it == 0) ? 50 : $urandom_range(30, 100);
            cfg_len = LEN_WIDTH'(len); cfg_gap = GAP_WIDTH'(gap); cfg_count = 16'(cnt); cfg_enable = 1'b1;
            build_exp(len, cnt);
            collect(400, pct, -1);
            n_checks++;
            if (got_q.size() != exp_q.size()) begin
                $display("FAIL bp_len it%0d: got %0d beats, required %0d", it, got_q.size(), exp_q.size());
                n_errors++;
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    $display("FAIL bp_beat it%0d [%0d]: got %h, required %h", it, i, got_q[i], exp_q[i]);
                    n_errors++;
                end
            end
            n_checks++;
            if (stab_err != 0) begin
                $display("FAIL bp_stable it%0d: %0d stall cycles changed outputs, required 0", it, stab_err);
                n_errors++;
            end
            for (int i = 0; i < gaps_q.size(); i++) begin
                n_checks++;
                if (gaps_q[i] != gap) begin
                    $display("FAIL bp_gap it%0d [%0d]: got %0d idle cycles, required %0d", it, i, gaps_q[i], gap);
                    n_errors++;
                end
            end
            n_checks++;
            if (frames_sent !== 32'(cnt) || fd_pulses != cnt || fd_bad != 0) begin
                $display("FAIL bp_frames it%0d: frames_sent=%0d pulses=%0d misplaced=%0d, required %0d/%0d/0",
                         it, frames_sent, fd_pulses, fd_bad, cnt, cnt);
                n_errors++;
            end
            go_idle();
        end
    endtask

    task automatic test_enable_drop();
        cfg_len = 16'd7; cfg_gap = 8'd0; cfg_count = 16'd0; cfg_enable = 1'b1;
        build_exp(7, 1);
        collect(20, 100, 3);
        n_checks++;
        if (got_q.size() != 8) begin
            $display("FAIL drop_len: got %0d beats, required 8", got_q.size());
            n_errors++;
        end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL drop_beat[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
                n_errors++;
            end
        end
        n_checks++;
        if (busy !== 1'b0 || m_axis_tvalid !== 1'b0 || frames_sent !== 32'd1) begin
            $display("FAIL drop_idle: busy=%0b tvalid=%0b frames_sent=%0d, required 0/0/1", busy, m_axis_tvalid, frames_sent);
            n_errors++;
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        cfg_len = 16'd7; cfg_gap = 8'd0; cfg_count = 16'd0; cfg_enable = 1'b1;
        collect(13, 100, -1);
        n_checks++;
        if (frames_sent !== 32'd1 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== DATA_WIDTH'(4)) begin
            $display("FAIL rst_pre: frames_sent=%0d tvalid=%0b tdata=%0d, required 1/1/4", frames_sent, m_axis_tvalid, m_axis_tdata);
            n_errors++;
        end
        areset = 1'b1;
        tick();
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || frames_sent !== 32'd0 || busy !== 1'b0) begin
            $display("FAIL rst_mid: tvalid=%0b tlast=%0b frames_sent=%0d busy=%0b, required 0/0/0/0",
                     m_axis_tvalid, m_axis_tlast, frames_sent, busy);
            n_errors++;
        end
        areset = 1'b0;
        build_exp(7, 1);
        collect(6, 100, -1);
        n_checks++;
        if (first_valid != 1 || got_q.size() < 3) begin
            $display("FAIL rst_restart: first valid cycle %0d beats %0d, required 1 and >=3", first_valid, got_q.size());
            n_errors++;
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL rst_beat[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
                n_errors++;
            end
        end
        go_idle();
    endtask

    task automatic test_seqnum();
        cfg_len = 16'd1; cfg_gap = 8'd0; cfg_count = 16'd3; cfg_enable = 1'b1;
        build_exp(1, 3);
        collect(15, 100, -1);
        n_checks++;
        if (got_q.size() != 6) begin
            $display("FAIL seq_len: got %0d beats, required 6", got_q.size());
            n_errors++;
        end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL seq_beat[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
                n_errors++;
            end
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_beat();
        test_backpressure();
        test_enable_drop();
        test_reset_mid();
        test_seqnum();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
